// File: rtl/servo_gate_ctrl.sv
// Dispensing-gate servo controller: framed PWM plus an open/hold/close ramp sequence.
// Optional macro IR_ABORT_EN: an obstacle seen while closing re-opens the gate.
module servo_gate_ctrl #(
    parameter int PERIOD_CYC  = 1000000,
    parameter int PW_CLOSED   = 50000,
    parameter int PW_OPEN     = 100000,
    parameter int STEP        = 5000,
    parameter int HOLD_FRAMES = 100
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic       en_duoji,
    input  logic       ir_flag,
    output logic       pwm_out,
    output logic       busy,
    output logic       done,
    output logic       gate_open,
    output logic [7:0] vend_count
);

    localparam int CNT_W  = $clog2(PERIOD_CYC);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int LAST_I = PERIOD_CYC - 1;
    localparam int HLAST_I = HOLD_FRAMES - 1;

    localparam logic [CNT_W-1:0]  C_LAST   = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  C_OPEN   = PW_OPEN[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  C_CLOSED = PW_CLOSED[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  C_STEP   = STEP[CNT_W-1:0];
    localparam logic [CNT_W:0]    X_OPEN   = PW_OPEN[CNT_W:0];
    localparam logic [CNT_W:0]    X_CLOSED = PW_CLOSED[CNT_W:0];
    localparam logic [CNT_W:0]    X_STEP   = STEP[CNT_W:0];
    localparam logic [HOLD_W-1:0] C_HLAST  = HLAST_I[HOLD_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_OPENING, S_HOLD, S_CLOSING} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_pw, w_pw_nxt, w_pw_up, w_pw_dn;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
    logic              r_en_s1, r_en_s2, r_en_d;
    logic              r_ir_s1, r_ir_s2;
    logic              r_pwm, r_done, w_done_nxt;
    logic [7:0]        r_vend, w_vend_nxt;
    logic              w_frame_start, w_trig, w_ir_abort;

    // Widen by one bit so a step past the limit clamps instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_up(input logic [CNT_W-1:0] pw_i);
        logic [CNT_W:0] sum;
        sum = {1'b0, pw_i} + X_STEP;
        return (sum >= X_OPEN) ? C_OPEN : sum[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_down(input logic [CNT_W-1:0] pw_i);
        return ({1'b0, pw_i} <= X_CLOSED + X_STEP) ? C_CLOSED : pw_i - C_STEP;
    endfunction

    assign w_frame_start = (r_frame_cnt == '0);
    assign w_trig        = r_en_s2 & ~r_en_d;
    assign w_pw_up       = sat_up(r_pw);
    assign w_pw_dn       = sat_down(r_pw);

`ifdef IR_ABORT_EN
    assign w_ir_abort = r_ir_s2;
`else
    logic w_unused_ir;
    assign w_unused_ir = r_ir_s2;
    assign w_ir_abort  = 1'b0;
`endif

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pw_nxt    = r_pw;
        w_hold_nxt  = r_hold_cnt;
        w_done_nxt  = 1'b0;
        w_vend_nxt  = r_vend;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = S_OPENING;
                end
            end
            S_OPENING: begin
                if (w_frame_start) begin
                    w_pw_nxt = w_pw_up;
                    if (w_pw_up == C_OPEN) begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (w_frame_start) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                    if (r_hold_cnt == C_HLAST) begin
                        w_state_nxt = S_CLOSING;
                    end
                end
            end
            S_CLOSING: begin
                if (w_frame_start) begin
                    if (w_ir_abort) begin
                        w_state_nxt = S_OPENING;
                    end else begin
                        w_pw_nxt = w_pw_dn;
                        if (w_pw_dn == C_CLOSED) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                            w_vend_nxt  = r_vend + 8'd1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame counter is free-running; pw only moves at frame start so pulses stay whole.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_en_s1     <= 1'b0;
            r_en_s2     <= 1'b0;
            r_en_d      <= 1'b0;
            r_ir_s1     <= 1'b0;
            r_ir_s2     <= 1'b0;
            r_frame_cnt <= '0;
            r_pw        <= C_CLOSED;
            r_hold_cnt  <= '0;
            r_pwm       <= 1'b0;
            r_done      <= 1'b0;
            r_vend      <= 8'd0;
        end else begin
            r_en_s1     <= en_duoji;
            r_en_s2     <= r_en_s1;
            r_en_d      <= r_en_s2;
            r_ir_s1     <= ir_flag;
            r_ir_s2     <= r_ir_s1;
            r_frame_cnt <= (r_frame_cnt == C_LAST) ? '0 : r_frame_cnt + 1'b1;
            r_pw        <= w_pw_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_pwm       <= (r_frame_cnt < r_pw);
            r_done      <= w_done_nxt;
            r_vend      <= w_vend_nxt;
        end
    end

    assign pwm_out    = r_pwm;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign gate_open  = (r_state == S_HOLD);
    assign vend_count = r_vend;

endmodule

// File: tb/tb_servo_gate_ctrl.sv
// Bench for servo_gate_ctrl: directed vector table, frame high-time lists, reset and
// wrap corners, and a random phase checked against a frame-schedule reference model.
module tb_servo_gate_ctrl;

    localparam int P  = 100;
    localparam int CL = 10;
    localparam int OP = 20;
    localparam int ST = 5;
    localparam int HF = 2;
`ifdef IR_ABORT_EN
    localparam bit IR_EN = 1'b1;
`else
    localparam bit IR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clr_n = 1'b0;
    logic       en    = 1'b0;
    logic       ir    = 1'b0;
    logic       pwm, busy, done, gate;
    logic [7:0] vend;
    logic       en2 = 1'b0;
    logic       ir2 = 1'b0;
    logic       pwm2, busy2, done2, gate2;
    logic [7:0] vend2;

    always #5 clock = ~clock;

    servo_gate_ctrl #(.PERIOD_CYC(P), .PW_CLOSED(CL), .PW_OPEN(OP), .STEP(ST), .HOLD_FRAMES(HF)) dut (
        .clock(clock), .clr_n(clr_n), .en_duoji(en), .ir_flag(ir),
        .pwm_out(pwm), .busy(busy), .done(done), .gate_open(gate), .vend_count(vend)
    );

    // Small instance so 256 sequences fit in a short run.
    servo_gate_ctrl #(.PERIOD_CYC(8), .PW_CLOSED(2), .PW_OPEN(4), .STEP(2), .HOLD_FRAMES(1)) dut2 (
        .clock(clock), .clr_n(clr_n), .en_duoji(en2), .ir_flag(ir2),
        .pwm_out(pwm2), .busy(busy2), .done(done2), .gate_open(gate2), .vend_count(vend2)
    );

    typedef struct {
        int pw;
        bit gate;
        bit down;
    } step_t;

    typedef struct {
        int cyc;
        bit en;
        bit ir;
        bit busy;
        bit gate;
        bit done;
        int vend;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc;
    bit    en_q[3];
    bit    ir_q[3];
    step_t sched[$];
    int    pw_m, vend_m;
    bit    gate_m, done_m;
    int    frame_hi, frame_exp;
    int    meas[64];
    int    done_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-sequence schedule of pw values taken at successive frame starts.
    task automatic build(input int p);
        step_t s;
        int v;
        v = p;
        do begin
            v = (v + ST > OP) ? OP : v + ST;
            s.pw = v; s.gate = (v == OP); s.down = 1'b0;
            sched.push_back(s);
        end while (v != OP);
        for (int i = 0; i < HF - 1; i++) begin
            s.pw = OP; s.gate = 1'b1; s.down = 1'b0;
            sched.push_back(s);
        end
        s.pw = OP; s.gate = 1'b0; s.down = 1'b0;
        sched.push_back(s);
        v = OP;
        do begin
            v = (v - ST < CL) ? CL : v - ST;
            s.pw = v; s.gate = 1'b0; s.down = 1'b1;
            sched.push_back(s);
        end while (v != CL);
    endtask

    task automatic model_reset();
        sched.delete();
        pw_m = CL; vend_m = 0; gate_m = 1'b0; done_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_q[i] = 1'b0;
            ir_q[i] = 1'b0;
        end
        cyc = 0; frame_hi = 0; frame_exp = CL;
        foreach (meas[i]) meas[i] = 0;
    endtask

    task automatic tick();
        bit en_now, ir_now, fs, trig, irs;
        int e;
        step_t s;
        en_now = en;
        ir_now = ir;
        @(posedge clock);
        #1;
        e = cyc;
        cyc++;
        fs   = ((e % P) == 0);
        trig = en_q[1] && !en_q[2];
        irs  = ir_q[1];
        en_q[2] = en_q[1]; en_q[1] = en_q[0]; en_q[0] = en_now;
        ir_q[2] = ir_q[1]; ir_q[1] = ir_q[0]; ir_q[0] = ir_now;
        done_m = 1'b0;
        if (sched.size() > 0) begin
            if (fs) begin
                if (sched[0].down && IR_EN && irs) begin
                    sched.delete();
                    build(pw_m);
                    gate_m = 1'b0;
                end else begin
                    s = sched.pop_front();
                    pw_m = s.pw;
                    gate_m = s.gate;
                    if (sched.size() == 0) begin
                        done_m = 1'b1;
                        vend_m = (vend_m + 1) % 256;
                    end
                end
            end
        end else if (trig) begin
            build(pw_m);
            gate_m = 1'b0;
        end
        if (fs) begin
            if (e > 0) chk("frame_high_time", frame_hi, frame_exp);
            frame_hi  = 0;
            frame_exp = pw_m;
        end
        frame_hi += int'(pwm);
        if (e / P < 64) meas[e / P] += int'(pwm);
        chk("busy", busy, int'(sched.size() > 0));
        chk("done", done, done_m);
        chk("gate_open", gate, gate_m);
        chk("vend_count", vend, vend_m);
        if (done) done_seen++;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        clr_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[20];
        int   fr_a[19] = '{10,10,10,15,20,20,20,15,10,10,10,10,10,15,20,20,20,15,10};
`ifdef IR_ABORT_EN
        int   fr_b[14] = '{10,10,15,20,20,20,15,15,20,20,20,15,10,10};
        int   vend_after_b = 3;
`else
        int   fr_b[14] = '{10,10,15,20,20,20,15,10,10,10,10,10,10,10};
        int   vend_after_b = 3;
`endif
        int   d0, n, en_left, ir_left;

        tbl[0]  = '{0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{250,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{252,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{253,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{400,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[5]  = '{401,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[6]  = '{450,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[7]  = '{480,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[8]  = '{600,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[9]  = '{601,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[10] = '{800,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{801,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[12] = '{802,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[13] = '{1200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[14] = '{1210, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[15] = '{1212, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[16] = '{1213, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[17] = '{1800, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[18] = '{1801, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[19] = '{1802, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};

        do_reset();
        chk("reset_pwm", pwm, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_gate", gate, 0);
        chk("reset_vend", vend, 0);

        // Idle framing, first sequence, ignored retrigger, second sequence.
        for (int i = 0; i < 20; i++) begin
            while (cyc < tbl[i].cyc) tick();
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_gate", i), gate, tbl[i].gate);
            chk($sformatf("vec%0d_done", i), done, tbl[i].done);
            chk($sformatf("vec%0d_vend", i), vend, tbl[i].vend);
            en = tbl[i].en;
            ir = tbl[i].ir;
        end
        while (cyc < 1900) tick();
        for (int f = 0; f < 19; f++) chk($sformatf("frame%0d_width", f), meas[f], fr_a[f]);

        // Obstacle present at the frame start after the first closing step.
        d0 = done_seen;
        while (cyc < 2050) tick();
        en = 1'b1;
        while (cyc < 2550) tick();
        ir = 1'b1;
        while (cyc < 2650) tick();
        ir = 1'b0;
        while (cyc < 3300) tick();
        for (int f = 0; f < 14; f++) chk($sformatf("ir_frame%0d_width", f + 19), meas[f + 19], fr_b[f]);
        chk("ir_done_pulses", done_seen - d0, 1);
        chk("ir_vend", vend, vend_after_b);

        // Reset while opening with pw=15 and the pulse high.
        en = 1'b0;
        while (cyc < 3320) tick();
        en = 1'b1;
        while (cyc < 3410) tick();
        chk("pre_reset_pwm", pwm, 1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("async_reset_pwm", pwm, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done, 0);
        chk("async_reset_vend", vend, 0);
        en = 1'b0;
        d0 = done_seen;
        do_reset();
        while (cyc < 201) tick();
        chk("post_reset_frame0", meas[0], CL);
        chk("post_reset_frame1", meas[1], CL);
        chk("post_reset_no_done", done_seen - d0, 0);
        chk("post_reset_vend", vend, 0);

        // Random enable / obstacle activity against the model.
        en_left = $urandom_range(1, 1500);
        ir_left = $urandom_range(1, 400);
        for (int i = 0; i < 20000; i++) begin
            en_left--;
            ir_left--;
            if (en_left == 0) begin
                en = ~en;
                en_left = $urandom_range(1, 1500);
            end
            if (ir_left == 0) begin
                ir = ~ir;
                ir_left = $urandom_range(1, 400);
            end
            tick();
        end
        en = 1'b0;
        ir = 1'b0;
        repeat (5) tick();
        n = 0;
        while (sched.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        tick();
        chk("random_settle_busy", busy, 0);

        // 256 short sequences on the small instance: count wraps 255 -> 0.
        for (int k = 1; k <= 256; k++) begin
            en2 = 1'b1;
            n = 0;
            while (!done2 && n < 200) begin
                tick();
                n++;
            end
            chk($sformatf("wrap_seq%0d_done", k), done2, 1);
            chk($sformatf("wrap_seq%0d_vend", k), vend2, k % 256);
            en2 = 1'b0;
            repeat (5) tick();
            chk($sformatf("wrap_seq%0d_busy", k), busy2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
